mtm_alu_deser_param: RTL

Parametrised serial-input deserializer for the ALU datapath. It receives a packet of 2*NBYTES data frames (operand B, then operand A, MSB byte first) followed by one command frame, checks framing, CRC and opcode, and presents operands on a single-entry valid/ready output. Errors are reported on a separate one-cycle error strobe with a one-hot code.

---
 rtl/mtm_alu_deser_param.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mtm_alu_deser_param.sv
// Serial packet deserializer: 2*NBYTES data frames (B then A) plus a command frame -> operands + opcode.
// Define MTM_DESER_TIMEOUT_EN to discard packets whose frames are separated by TIMEOUT_CYC idle cycles.
module mtm_alu_deser_param #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [2:0]        op_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_valid,
    output logic [3:0]        err_code
);
    localparam int NBYTES  = DATA_W / 8;
    localparam int NFRAMES = 2 * NBYTES;
    localparam int BCW     = $clog2(NFRAMES + 1);

    if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 64 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("mtm_alu_deser_param: unsupported DATA_W or TIMEOUT_CYC");
    end

    typedef enum logic [2:0] {S_IDLE, S_TYPE, S_PAYLOAD, S_STOP, S_CHECK, S_ERROR} state_t;

    state_t              state_q;
    logic                sin_q;
    logic [BCW-1:0]      byte_cnt_q;
    logic [2:0]          bit_cnt_q;
    logic                cmd_q;
    logic [3:0]          crc_q;
    logic [3:0]          rx_crc_q;
    logic [2:0]          op_q;
    logic [3:0]          run_q;
    logic [2*DATA_W-1:0] sh_q;
    logic [2*DATA_W-1:0] sh_d;
`ifdef MTM_DESER_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    logic [TCW-1:0]      idle_cnt_q;
`endif

    // Serial CRC4, x^4+x+1, MSB first.
    function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic b);
        logic fb;
        fb = c[3] ^ b;
        return {c[2], c[1], c[0] ^ fb, fb};
    endfunction

    function automatic logic op_is_valid(input logic [2:0] op);
        return (op[1] == 1'b0);
    endfunction

    always_comb sh_d = {sh_q[2*DATA_W-2:0], sin_q};

    // Operand shift register; fully rewritten by every packet, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state_q == S_PAYLOAD && !cmd_q) sh_q <= sh_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sin_q      <= 1'b1;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            cmd_q      <= 1'b0;
            crc_q      <= '0;
            rx_crc_q   <= '0;
            op_q       <= '0;
            run_q      <= '0;
            a_o        <= '0;
            b_o        <= '0;
            op_o       <= '0;
            out_valid  <= 1'b0;
            err_valid  <= 1'b0;
            err_code   <= '0;
`ifdef MTM_DESER_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
        end else begin
            sin_q     <= sin;
            err_valid <= 1'b0;
            err_code  <= '0;
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
`ifdef MTM_DESER_TIMEOUT_EN
                    if (!sin_q) begin
                        idle_cnt_q <= '0;
                        state_q    <= S_TYPE;
                    end else if (byte_cnt_q != '0) begin
                        if (idle_cnt_q == TCW'(TIMEOUT_CYC - 1)) begin
                            err_valid  <= 1'b1;
                            err_code   <= 4'b0001;
                            byte_cnt_q <= '0;
                            crc_q      <= '0;
                            idle_cnt_q <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + TCW'(1);
                        end
                    end
`else
                    if (!sin_q) state_q <= S_TYPE;
`endif
                end
                S_TYPE: begin
                    cmd_q     <= sin_q;
                    bit_cnt_q <= '0;
                    if ((!sin_q && byte_cnt_q == BCW'(NFRAMES)) ||
                        (sin_q && byte_cnt_q < BCW'(NFRAMES))) begin
                        state_q   <= S_ERROR;
                        err_valid <= 1'b1;
                        err_code  <= 4'b0001;
                    end else begin
                        state_q <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    // Command bit7 is replaced by a constant 1 in the CRC bit string.
                    if (!cmd_q) begin
                        crc_q <= crc4_step(crc_q, sin_q);
                    end else if (bit_cnt_q == 3'd0) begin
                        crc_q <= crc4_step(crc_q, 1'b1);
                    end else if (bit_cnt_q < 3'd4) begin
                        crc_q <= crc4_step(crc_q, sin_q);
                        op_q  <= {op_q[1:0], sin_q};
                    end else begin
                        rx_crc_q <= {rx_crc_q[2:0], sin_q};
                    end
                    if (bit_cnt_q == 3'd7) state_q <= S_STOP;
                end
                S_STOP: begin
                    if (!sin_q) begin
                        state_q   <= S_ERROR;
                        err_valid <= 1'b1;
                        err_code  <= 4'b0001;
                    end else if (cmd_q) begin
                        state_q <= S_CHECK;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + BCW'(1);
                        state_q    <= S_IDLE;
                    end
                end
                S_CHECK: begin
                    if (crc_q != rx_crc_q) begin
                        state_q   <= S_ERROR;
                        err_valid <= 1'b1;
                        err_code  <= 4'b0010;
                    end else if (!op_is_valid(op_q)) begin
                        state_q   <= S_ERROR;
                        err_valid <= 1'b1;
                        err_code  <= 4'b0100;
                    end else begin
                        state_q    <= S_IDLE;
                        byte_cnt_q <= '0;
                        crc_q      <= '0;
                        if (out_valid && !out_ready) begin
                            err_valid <= 1'b1;
                            err_code  <= 4'b1000;
                        end else begin
                            a_o       <= sh_q[DATA_W-1:0];
                            b_o       <= sh_q[2*DATA_W-1:DATA_W];
                            op_o      <= op_q;
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_ERROR: begin
                    byte_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    crc_q      <= '0;
                    // Resync: leave only after 11 consecutive idle-high samples.
                    if (!sin_q) begin
                        run_q <= '0;
                    end else if (run_q == 4'd10) begin
                        run_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        run_q <= run_q + 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
